// File: rtl/decode_h1_pipe.sv
// -----------------------------------------------------------------------------
// decode_h1_pipe
//
// Two-stage pipelined SECDED decoder for the 8-bit H1 codeword
// {d3,d2,d1,d0,p3,p2,p1,p0}: four data bits, three Hamming parity bits and
// one overall parity bit. Single-bit errors are corrected and double-bit
// errors are flagged. Two saturating counters track how many words of each
// error kind have been handed downstream.
//
// Both sides use valid/ready handshakes. A single enable (en) advances the
// whole pipeline. en is high whenever the output register is empty or is
// being drained, so a stalled output freezes both stages.
//
// Optional build macro DECODE_H1_ERR_LOG_EN:
//   Adds ERR_LOG / ERR_LOG_VALID. They hold the raw codeword of the first
//   double-error word handed downstream since reset or CNT_CLR. Without the
//   macro these ports and their logic do not exist.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   CodeWord[7:0]  received word {d3,d2,d1,d0,p3,p2,p1,p0}
//   IN_VALID       CodeWord valid
//   IN_READY       decoder accepts a word this cycle
//   DATA_OUT[3:0]  decoded (corrected) data
//   SYNDROME[3:0]  {overall, s2, s1, s0} of the word on DATA_OUT
//   SINGLE_ERR     correctable error detected and fixed
//   DOUBLE_ERR     uncorrectable error
//   OUT_VALID      DATA_OUT, SYNDROME and flags valid
//   OUT_READY      downstream accepts
//   CNT_CLR        synchronous clear of both counters (beats an increment)
//   SB_CNT         saturating single-error count
//   DB_CNT         saturating double-error count
//   ERR_LOG[7:0]   first double-error raw codeword (macro only)
//   ERR_LOG_VALID  ERR_LOG holds a capture (macro only)
// -----------------------------------------------------------------------------
module decode_h1_pipe #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           CodeWord,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    output logic [3:0]           DATA_OUT,
    output logic [3:0]           SYNDROME,
    output logic                 SINGLE_ERR,
    output logic                 DOUBLE_ERR,
    output logic                 OUT_VALID,
    input  logic                 OUT_READY,
    input  logic                 CNT_CLR,
    output logic [CNT_WIDTH-1:0] SB_CNT,
    output logic [CNT_WIDTH-1:0] DB_CNT
`ifdef DECODE_H1_ERR_LOG_EN
    ,
    output logic [7:0]           ERR_LOG,
    output logic                 ERR_LOG_VALID
`endif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic       en;
    logic       out_fire;
    logic       s1_valid;
    logic [7:0] s1_word;

    logic [3:0] raw_data;
    logic [2:0] syn;
    logic       overall;
    logic [3:0] corr_data;
    logic       single_nxt;
    logic       double_nxt;

    assign en       = !OUT_VALID || OUT_READY;
    assign IN_READY = en;
    assign out_fire = OUT_VALID && OUT_READY;

    // Stage 1: capture the incoming word.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_word  <= '0;
        end else if (en) begin
            s1_valid <= IN_VALID;
            if (IN_VALID) begin
                s1_word <= CodeWord;
            end
        end
    end

    // Stage 2 combinational decode of the stage-1 word.
    assign raw_data = s1_word[7:4];
    assign syn[0]   = s1_word[0] ^ s1_word[4] ^ s1_word[5] ^ s1_word[7];
    assign syn[1]   = s1_word[1] ^ s1_word[4] ^ s1_word[6] ^ s1_word[7];
    assign syn[2]   = s1_word[2] ^ s1_word[5] ^ s1_word[6] ^ s1_word[7];
    assign overall  = ^s1_word;

    // NOTE: every signal written in this block gets a default first, so no
    // path through the case/if tree can infer a latch.
    always_comb begin
        corr_data  = raw_data;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        if (overall) begin
            // Odd overall parity: exactly one bit flipped. Only data-bit
            // positions need fixing; parity-bit and p3 errors leave data intact.
            single_nxt = s1_valid;
            unique case (syn)
                3'b011:  corr_data[0] = ~raw_data[0];
                3'b101:  corr_data[1] = ~raw_data[1];
                3'b110:  corr_data[2] = ~raw_data[2];
                3'b111:  corr_data[3] = ~raw_data[3];
                default: corr_data    = raw_data;
            endcase
        end else if (syn != 3'b000) begin
            // Even overall parity with a nonzero syndrome: two bits flipped.
            double_nxt = s1_valid;
        end
    end

    // Stage 2 output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_VALID  <= 1'b0;
            DATA_OUT   <= '0;
            SYNDROME   <= '0;
            SINGLE_ERR <= 1'b0;
            DOUBLE_ERR <= 1'b0;
        end else if (en) begin
            OUT_VALID  <= s1_valid;
            DATA_OUT   <= corr_data;
            SYNDROME   <= {overall, syn};
            SINGLE_ERR <= single_nxt;
            DOUBLE_ERR <= double_nxt;
        end
    end

    // Error counters: count on the output handshake, saturate at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            SB_CNT <= '0;
            DB_CNT <= '0;
        end else if (CNT_CLR) begin
            SB_CNT <= '0;
            DB_CNT <= '0;
        end else if (out_fire) begin
            if (SINGLE_ERR && SB_CNT != CNT_MAX) begin
                SB_CNT <= SB_CNT + CNT_WIDTH'(1);
            end
            if (DOUBLE_ERR && DB_CNT != CNT_MAX) begin
                DB_CNT <= DB_CNT + CNT_WIDTH'(1);
            end
        end
    end

`ifdef DECODE_H1_ERR_LOG_EN
    // Raw codeword travelling alongside the stage-2 results.
    logic [7:0] s2_word;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_word <= '0;
        end else if (en) begin
            s2_word <= s1_word;
        end
    end

    // Sticky capture of the first double error since reset or clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ERR_LOG       <= '0;
            ERR_LOG_VALID <= 1'b0;
        end else if (CNT_CLR) begin
            ERR_LOG       <= '0;
            ERR_LOG_VALID <= 1'b0;
        end else if (out_fire && DOUBLE_ERR && !ERR_LOG_VALID) begin
            ERR_LOG       <= s2_word;
            ERR_LOG_VALID <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/decode_h1_pipe.md
Name: decode_h1_pipe

Overview:
- Pipelined SECDED decoder for the 8-bit H1 codeword: 4 data bits, 3 Hamming parity bits, 1 overall parity bit.
- Corrects single-bit errors and flags double-bit errors.
- Keeps saturating error counters.
- Sits on the receive side of the H1 path, opposite the H1 encoder, with valid/ready handshakes on both sides.

Parameters:
CNT_WIDTH, 16, width of each saturating error counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
CodeWord  input  8  received word, {d3,d2,d1,d0,p3,p2,p1,p0}.
IN_VALID  input  1  CodeWord valid.
IN_READY  output  1  decoder accepts a word this cycle.
DATA_OUT  output  4  decoded data.
SYNDROME  output  4  {overall, s2, s1, s0} for the word on DATA_OUT.
SINGLE_ERR  output  1  correctable error detected and fixed.
DOUBLE_ERR  output  1  uncorrectable error.
OUT_VALID  output  1  DATA_OUT and flags valid.
OUT_READY  input  1  downstream accepts.
CNT_CLR  input  1  synchronous clear of both counters.
SB_CNT  output  CNT_WIDTH  single-error count.
DB_CNT  output  CNT_WIDTH  double-error count.

Behaviour:
- Reset: async on rst low; all pipeline valids, data, flags, SYNDROME and counters go to 0. IN_READY=1 once out of reset.
- Stall enable: en = !OUT_VALID || OUT_READY. IN_READY = en. All stages advance only when en=1.
- Stage 1: on IN_VALID && IN_READY, register CodeWord and set s1_valid; otherwise s1_valid<=0 (when en).
- Stage 2 syndrome:
  - s0 = p0^d0^d1^d3
  - s1 = p1^d0^d2^d3
  - s2 = p2^d1^d2^d3
  - overall = XOR of all 8 bits
- Stage 2 syndrome-to-bit map (s2s1s0): 001=p0, 010=p1, 100=p2, 011=d0, 101=d1, 110=d2, 111=d3.
- Stage 2 classification:
  - overall=0, syn=000: clean; DATA_OUT = raw data.
  - overall=1: SINGLE_ERR=1. If syn maps to a data bit, invert that bit in DATA_OUT. If syn=000 (p3 error) or syn maps to a parity bit, DATA_OUT = raw data.
  - overall=0, syn≠000: DOUBLE_ERR=1; DATA_OUT = raw uncorrected data.
  - Results and OUT_VALID are registered at stage 2.
- Latency: 2 cycles from accepting handshake to OUT_VALID with no stall. Throughput: 1 word/cycle while OUT_READY=1.
- Stall: OUT_VALID=1 && OUT_READY=0 freezes both stages; outputs hold stable. IN_READY=0.
- Counters:
  - On OUT_VALID && OUT_READY, increment SB_CNT if SINGLE_ERR, or DB_CNT if DOUBLE_ERR.
  - Saturate at all-ones with no wrap.
  - CNT_CLR has priority over a simultaneous increment: result is 0.
- Flags and SYNDROME are meaningful only while OUT_VALID=1. SINGLE_ERR and DOUBLE_ERR are never both 1.
- Reset mid-stream: in-flight words are discarded, no output is produced for them, and counters go to 0.

Optional Feature:
- Macro: DECODE_H1_ERR_LOG_EN.
- Defined:
  - Adds outputs ERR_LOG[7:0] and ERR_LOG_VALID.
  - On the first DOUBLE_ERR output handshake after reset or CNT_CLR, capture the stage-2 raw CodeWord into ERR_LOG and set ERR_LOG_VALID. Both are sticky until CNT_CLR or reset, which set them to 0.
  - Later double errors do not overwrite the log.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Clean word: CodeWord=8'hB1, IN_VALID=1, OUT_READY=1 -> 2 cycles later DATA_OUT=4'hB, SYNDROME=4'h0, both flags 0, counters unchanged.
- Data-bit error: 8'hF1 (d2 flipped) -> DATA_OUT=4'hB, SYNDROME=4'hE, SINGLE_ERR=1, SB_CNT=1.
- p3 error: 8'hB9 -> DATA_OUT=4'hB, SYNDROME=4'h8, SINGLE_ERR=1.
- Double error: 8'hF0 -> DOUBLE_ERR=1, SYNDROME=4'h7, DATA_OUT=4'hF, DB_CNT=1. With the macro defined, ERR_LOG=8'hF0 and ERR_LOG_VALID=1.
- Back-pressure: stream 8'h00, 8'hB1, 8'hF1; hold OUT_READY=0 for 3 cycles -> IN_READY=0, outputs frozen, no word lost or duplicated, order preserved. Separately, CNT_CLR asserted in the same cycle as a counting handshake -> counter reads 0.
- Saturation and reset: CNT_WIDTH=2, send 5 single-error words -> SB_CNT=3. Assert rst low mid-stream -> OUT_VALID=0, counters 0, no stale output after release.
